// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer for an N_IN-input combinational gate.
// Optional first-mismatch capture: define TT_SWEEP_MISMATCH_CAPTURE_EN.
module tt_sweep_ctrl #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED_TT = 16'h1AC6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] tt,
    output logic                 match
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
    ,
    output logic                 mm_vld,
    output logic [N_IN-1:0]      mm_idx
`endif
);

    localparam int NV = 1 << N_IN;
    localparam int CW =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NV-1:0]   tt_q, tt_d;
    logic            match_q, match_d;
    logic [NV-1:0]   tt_merged;
    logic            sample;

`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
    logic            mm_vld_q, mm_vld_d;
    logic [N_IN-1:0] mm_idx_q, mm_idx_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tt_d      = tt_q;
        match_d   = match_q;
        sample    = 1'b0;
        tt_merged = tt_q;
        // current sample folded in so the final compare sees all bits
        tt_merged[idx_q] = dut_out;
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
        mm_vld_d = mm_vld_q;
        mm_idx_d = mm_idx_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                    tt_d    = '0;
                    match_d = 1'b0;
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
                    mm_vld_d = 1'b0;
                    mm_idx_d = '0;
`endif
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    match_d = 1'b0;
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
                    mm_vld_d = 1'b0;
                    mm_idx_d = '0;
`endif
                end else if (cnt_q == '0) begin
                    sample = 1'b1;
                    tt_d   = tt_merged;
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = S_DONE;
                        match_d = (tt_merged == EXPECTED_TT);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
        if (sample && !mm_vld_q &&
            (dut_out != EXPECTED_TT[idx_q])) begin
            mm_vld_d = 1'b1;
            mm_idx_d = idx_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            match_q <= match_d;
        end
    end

`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mm_vld_q <= 1'b0;
            mm_idx_q <= '0;
        end else begin
            mm_vld_q <= mm_vld_d;
            mm_idx_q <= mm_idx_d;
        end
    end

    assign mm_vld = mm_vld_q;
    assign mm_idx = mm_idx_q;
`endif

    // idx doubles as the driven vector, so dut_in is glitch-free
    assign dut_in = idx_q;
    assign busy   = (state_q == S_DRIVE);
    assign done   = (state_q == S_DONE);
    assign tt     = tt_q;
    assign match  = match_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized self-checking bench for tt_sweep_ctrl.
// Instance A: default params; instance B: N_IN=2, SETTLE=1, 4'h6.
module tb_tt_sweep_ctrl;

    localparam logic [15:0] EXP_A = 16'h1AC6;
    localparam logic [15:0] EXP_B = 16'h0006;

    logic        clk = 1'b0;
    logic        rst_a, start_a, abort_a, out_a;
    logic        rst_b, start_b, abort_b, out_b;
    logic [3:0]  dut_in_a;
    logic [1:0]  dut_in_b;
    logic        busy_a, done_a, match_a;
    logic        busy_b, done_b, match_b;
    logic [15:0] tt_a;
    logic [3:0]  tt_b;
    logic [15:0] gate_a;
    logic [3:0]  gate_b;
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
    logic        mm_vld_a, mm_vld_b;
    logic [3:0]  mm_idx_a;
    logic [1:0]  mm_idx_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign out_a = gate_a[dut_in_a];
    assign out_b = gate_b[dut_in_b];

    tt_sweep_ctrl u_a (
        .clk     (clk),
        .rst     (rst_a),
        .start   (start_a),
        .abort   (abort_a),
        .dut_in  (dut_in_a),
        .dut_out (out_a),
        .busy    (busy_a),
        .done    (done_a),
        .tt      (tt_a),
        .match   (match_a)
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
        ,
        .mm_vld  (mm_vld_a),
        .mm_idx  (mm_idx_a)
`endif
    );

    tt_sweep_ctrl #(
        .N_IN          (2),
        .SETTLE_CYCLES (1),
        .EXPECTED_TT   (4'h6)
    ) u_b (
        .clk     (clk),
        .rst     (rst_b),
        .start   (start_b),
        .abort   (abort_b),
        .dut_in  (dut_in_b),
        .dut_out (out_b),
        .busy    (busy_b),
        .done    (done_b),
        .tt      (tt_b),
        .match   (match_b)
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
        ,
        .mm_vld  (mm_vld_b),
        .mm_idx  (mm_idx_b)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s,
                         input logic a, input logic r);
        if (sel != 0) begin
            start_b = s; abort_b = a; rst_b = r;
        end else begin
            start_a = s; abort_a = a; rst_a = r;
        end
    endtask

    function automatic logic [31:0] rd_busy(input int sel);
        return (sel != 0) ? 32'(busy_b) : 32'(busy_a);
    endfunction

    function automatic logic [31:0] rd_done(input int sel);
        return (sel != 0) ? 32'(done_b) : 32'(done_a);
    endfunction

    function automatic logic [31:0] rd_in(input int sel);
        return (sel != 0) ? 32'(dut_in_b) : 32'(dut_in_a);
    endfunction

    function automatic logic [31:0] rd_tt(input int sel);
        return (sel != 0) ? 32'(tt_b) : 32'(tt_a);
    endfunction

    function automatic logic [31:0] rd_match(input int sel);
        return (sel != 0) ? 32'(match_b) : 32'(match_a);
    endfunction

    task automatic chk_zero(input int sel, input string tag);
        chk({tag, ".busy"}, rd_busy(sel), 0);
        chk({tag, ".done"}, rd_done(sel), 0);
        chk({tag, ".tt"}, rd_tt(sel), 0);
        chk({tag, ".match"}, rd_match(sel), 0);
        chk({tag, ".dut_in"}, rd_in(sel), 0);
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
        chk({tag, ".mm_vld"},
            (sel != 0) ? 32'(mm_vld_b) : 32'(mm_vld_a), 0);
`endif
    endtask

    // ev: 0 plain, 1 stray starts, 2 abort at cycle `at`, 3 rst at `at`
    task automatic sweep(input int sel, input logic [15:0] gate,
                         input int ev, input int at);
        int nv, s, t;
        logic [15:0] ex, msk, g;
        bit killed;
        nv = (sel != 0) ? 4 : 16;
        s = (sel != 0) ? 1 : 2;
        ex = (sel != 0) ? EXP_B : EXP_A;
        msk = (sel != 0) ? 16'h000F : 16'hFFFF;
        t = nv * s;
        g = gate & msk;
        killed = 0;
        if (sel != 0) gate_b = g[3:0];
        else gate_a = g;
        @(negedge clk);
        chk("idle.busy", rd_busy(sel), 0);
        drive(sel, 1, 0, 0);
        for (int k = 0; k < t; k++) begin
            @(negedge clk);
            drive(sel, 0, 0, 0);
            chk("run.busy", rd_busy(sel), 1);
            chk("run.done", rd_done(sel), 0);
            chk("run.dut_in", rd_in(sel), k / s);
            chk("run.tt", rd_tt(sel),
                32'(g) & ((32'h1 << (k / s)) - 1));
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
            if (k == 0 && sel == 0) chk("run.mm_vld", mm_vld_a, 0);
`endif
            if (ev == 1 && k == at) drive(sel, 1, 0, 0);
            if (ev == 2 && k == at) begin
                drive(sel, 0, 1, 0);
                killed = 1;
                break;
            end
            if (ev == 3 && k == at) begin
                drive(sel, 0, 0, 1);
                killed = 1;
                break;
            end
        end
        if (killed) begin
            @(negedge clk);
            drive(sel, 0, 0, 0);
            chk_zero(sel, (ev == 2) ? "abort" : "rst");
            if (ev == 3) drive(sel, 1, 1, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                drive(sel, 0, 0, 0);
                chk("post.busy", rd_busy(sel), 0);
                chk("post.done", rd_done(sel), 0);
            end
            return;
        end
        @(negedge clk);
        chk("end.done", rd_done(sel), 1);
        chk("end.busy", rd_busy(sel), 0);
        chk("end.tt", rd_tt(sel), 32'(g));
        chk("end.match", rd_match(sel), 32'(g == ex));
        chk("end.dut_in", rd_in(sel), nv - 1);
`ifdef TT_SWEEP_MISMATCH_CAPTURE_EN
        if (sel == 0) begin
            logic [15:0] d;
            int first;
            d = g ^ ex;
            first = 0;
            for (int v = 15; v >= 0; v--)
                if (d[v]) first = v;
            chk("end.mm_vld", mm_vld_a, 32'(d != 0));
            if (d != 0) chk("end.mm_idx", mm_idx_a, first);
        end
`endif
        if (ev == 1) drive(sel, 1, 0, 0);
        @(negedge clk);
        drive(sel, 0, 0, 0);
        chk("hold.done", rd_done(sel), 0);
        chk("hold.busy", rd_busy(sel), 0);
        chk("hold.tt", rd_tt(sel), 32'(g));
        chk("hold.match", rd_match(sel), 32'(g == ex));
        chk("hold.dut_in", rd_in(sel), nv - 1);
    endtask

    initial begin
        gate_a = EXP_A;
        gate_b = EXP_B[3:0];
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk_zero(0, "reset_a");
        chk_zero(1, "reset_b");
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);

        sweep(0, EXP_A, 0, 0);
        sweep(0, 16'h1AE6, 0, 0);
        sweep(0, EXP_A, 1, 10);
        sweep(0, EXP_A, 0, 0);
        sweep(0, 16'(EXP_A ^ $urandom), 2, 14);
        sweep(0, EXP_A, 0, 0);
        sweep(0, 16'($urandom), 3, 24);
        sweep(1, EXP_B, 0, 0);
        sweep(1, 16'h0009, 0, 0);

        for (int r = 0; r < 40; r++) begin
            int sel, ev, at;
            logic [15:0] g;
            sel = int'($urandom_range(0, 1));
            ev = int'($urandom_range(0, 3));
            at = int'($urandom_range(0, (sel != 0) ? 3 : 31));
            g = ($urandom_range(0, 2) == 0)
                ? ((sel != 0) ? EXP_B : EXP_A)
                : 16'($urandom);
            sweep(sel, g, ev, at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
